// File: rtl/adder_ctrl_pkg.sv
// Shared types and defaults for the adder-sharing controller.
// Holds the FSM state enum, timing defaults and an index-width helper.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned START_CYC_DEF = 2;
  localparam int unsigned TIMEOUT_DEF   = 255;

  // Ceiling log2, never below 1 so a 2-entry index still has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester and adder-side signal bundle for adder_share_arbiter.
// slave is the controller's view; master is the requesters/adder view.
interface adder_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_carry;
    logic                  rsp_err;
    logic                  busy;

    logic                  add_start;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_done;
    logic [WIDTH-1:0]      add_result;
    logic                  add_carry;

    modport slave (
        input  req, op_a, op_b, add_done, add_result, add_carry,
        output ack, rsp_result, rsp_carry, rsp_err, busy, add_start, add_a, add_b
    );

    modport master (
        output req, op_a, op_b, add_done, add_result, add_carry,
        input  ack, rsp_result, rsp_carry, rsp_err, busy, add_start, add_a, add_b
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, with wrap.
module rr_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_req_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found     = 1'b1;
                gnt_idx_o = cand[IdxW-1:0];
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one serial adder among NREQ requesters with round-robin grant,
// start/done handshake and a watchdog that aborts a stuck operation.
module adder_share_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned START_CYC = START_CYC_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    adder_share_arbiter_if.slave bus
);

    localparam int unsigned     IdxW       = clog2(NREQ);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NREQ - 1);
    localparam logic [7:0]      StartLast  = 8'(START_CYC - 1);
    localparam logic [7:0]      TimeoutVal = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        start_cnt_q, start_cnt_d;
    logic [7:0]        wdog_q, wdog_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              err_q, err_d;

    logic [IdxW-1:0]   arb_idx;
    logic              any_req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i     (bus.req),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        start_cnt_d = start_cnt_q;
        wdog_d      = wdog_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        result_d    = result_q;
        carry_d     = carry_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d     = arb_idx;
                    add_a_d     = bus.op_a[32'(arb_idx) * WIDTH +: WIDTH];
                    add_b_d     = bus.op_b[32'(arb_idx) * WIDTH +: WIDTH];
                    start_cnt_d = '0;
                    wdog_d      = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (start_cnt_q == StartLast) begin
                    state_d = StWait;
                end else begin
                    start_cnt_d = start_cnt_q + 8'd1;
                end
            end
            StWait: begin
                // A done in the same cycle as expiry still wins over the abort.
                if (bus.add_done) begin
                    result_d = bus.add_result;
                    carry_d  = bus.add_carry;
                    err_d    = 1'b0;
                    state_d  = StResp;
                end else if (wdog_q == TimeoutVal) begin
                    result_d = '0;
                    carry_d  = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            StResp: begin
                rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ack = '0;
        if (state_q == StResp) begin
            bus.ack[grant_q] = 1'b1;
        end
        bus.busy       = (state_q != StIdle);
        bus.add_start  = (state_q == StIssue);
        bus.add_a      = add_a_q;
        bus.add_b      = add_b_q;
        bus.rsp_result = result_q;
        bus.rsp_carry  = carry_q;
        bus.rsp_err    = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            start_cnt_q <= '0;
            wdog_q      <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            start_cnt_q <= start_cnt_d;
            wdog_q      <= wdog_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a small serial-adder model.
module tb_adder_share_arbiter;

    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hang = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       m_busy;
    logic [3:0] m_cnt;

    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NREQ(4), .WIDTH(64)) bus ();

    adder_share_arbiter #(
        .NREQ      (4),
        .WIDTH     (64),
        .START_CYC (2),
        .TIMEOUT   (255)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Adder model: one-cycle done pulse LAT cycles after start drops; hang suppresses it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy         <= 1'b0;
            m_cnt          <= '0;
            bus.add_done   <= 1'b0;
            bus.add_result <= '0;
            bus.add_carry  <= 1'b0;
        end else begin
            bus.add_done <= 1'b0;
            if (bus.add_start) begin
                m_busy <= 1'b1;
                m_cnt  <= 4'(LAT);
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    if (!hang) begin
                        bus.add_done <= 1'b1;
                        {bus.add_carry, bus.add_result} <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
                    end
                end else begin
                    m_cnt <= m_cnt - 4'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output bit ok, output int starts, output int waits);
        ok = 1'b0;
        starts = 0;
        waits = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                ok = 1'b1;
                break;
            end
            if (bus.add_start) starts++;
            else if (starts > 0) waits++;
        end
    endtask

    task automatic do_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_r, input logic exp_c, input logic exp_e,
                         input string tag, output int waits);
        bit ok;
        int s;
        bus.op_a[idx*64 +: 64] = a;
        bus.op_b[idx*64 +: 64] = b;
        bus.req[idx] = 1'b1;
        wait_ack(ok, s, waits);
        check({tag, ".seen"}, 64'(ok), 64'd1);
        check({tag, ".ack"}, 64'(bus.ack), 64'(4'b0001 << idx));
        check({tag, ".starts"}, 64'(s), 64'd2);
        check({tag, ".result"}, bus.rsp_result, exp_r);
        check({tag, ".carry"}, 64'(bus.rsp_carry), 64'(exp_c));
        check({tag, ".err"}, 64'(bus.rsp_err), 64'(exp_e));
        bus.req[idx] = 1'b0;
        @(negedge clk);
        check({tag, ".ack_pulse"}, 64'(bus.ack), 64'd0);
    endtask

    initial begin
        logic [63:0] rr_exp [4];
        bit ok;
        int s, w;

        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.ack", 64'(bus.ack), 64'd0);
        check("rst.start", 64'(bus.add_start), 64'd0);
        check("rst.add_a", bus.add_a, 64'd0);
        check("rst.result", bus.rsp_result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 64'h17, 64'hF, 64'h26, 1'b0, 1'b0, "op0", w);
        do_op(2, 64'h0000435567000009, 64'h0012345790000005, 64'h001277ACF700000E,
              1'b0, 1'b0, "op2", w);
        do_op(1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 1'b1, 1'b0, "op1", w);

        // Round robin from a freshly reset pointer with all requests held.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_exp = '{64'h33, 64'h1055, 64'h2077, 64'h3099};
        bus.op_a = {64'h3011, 64'h2011, 64'h1011, 64'h11};
        bus.op_b = {64'h88, 64'h66, 64'h44, 64'h22};
        bus.req  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack(ok, s, w);
            check($sformatf("rr%0d.ack", k), 64'(bus.ack), 64'(4'b0001 << (k % 4)));
            check($sformatf("rr%0d.result", k), bus.rsp_result, rr_exp[k % 4]);
        end
        bus.req = '0;
        @(negedge clk);

        // Watchdog: pointer is now 1, only requester 3 asks.
        hang = 1'b1;
        do_op(3, 64'h5, 64'h6, 64'h0, 1'b0, 1'b1, "tmo", w);
        check("tmo.wait_cycles", 64'(w), 64'd256);
        hang = 1'b0;
        do_op(0, 64'h17, 64'hF, 64'h26, 1'b0, 1'b0, "after_tmo", w);

        // Reset in WAIT: pointer is 1 here, so a grant to 0 afterwards shows it was cleared.
        hang = 1'b1;
        bus.op_a[2*64 +: 64] = 64'hABCD;
        bus.op_b[2*64 +: 64] = 64'h1234;
        bus.req[2] = 1'b1;
        repeat (10) @(negedge clk);
        check("mid.busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid.busy", 64'(bus.busy), 64'd0);
        check("mid.start", 64'(bus.add_start), 64'd0);
        check("mid.add_a", bus.add_a, 64'd0);
        check("mid.add_b", bus.add_b, 64'd0);
        check("mid.ack", 64'(bus.ack), 64'd0);
        check("mid.result", bus.rsp_result, 64'd0);
        check("mid.carry", 64'(bus.rsp_carry), 64'd0);
        check("mid.err", 64'(bus.rsp_err), 64'd0);
        bus.req = '0;
        hang = 1'b0;
        repeat (2) @(negedge clk);
        check("mid.ack_in_rst", 64'(bus.ack), 64'd0);
        rst_n = 1'b1;
        bus.op_a[63:0] = 64'h17;
        bus.op_b[63:0] = 64'hF;
        bus.req = 4'hF;
        wait_ack(ok, s, w);
        check("post_rst.seen", 64'(ok), 64'd1);
        check("post_rst.ack", 64'(bus.ack), 64'd1);
        check("post_rst.result", bus.rsp_result, 64'h26);
        bus.req = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin controller that shares one quadSerialAdder instance among NREQ requesters. It selects a pending request, registers that requester's operands, drives the adder's start/done handshake and returns the sum and carry to the granted requester with a one-cycle acknowledge. A watchdog aborts any operation that never completes. The block sits between the requesting units and the adder in the top level.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 64, operand/result width; matches the adder
- START_CYC, 2, cycles add_start is held high per operation
- TIMEOUT, 255, max WAIT cycles before abort (8-bit counter)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester; held high with operands stable until its ack
- op_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- op_b  in  NREQ*WIDTH  operand B, same packing
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rsp_result  out  WIDTH  sum, valid while any ack bit is high
- rsp_carry  out  1  carry-out, valid with ack
- rsp_err  out  1  high with ack if the operation timed out
- busy  out  1  high in every state except IDLE
- add_start  out  1  to adder start
- add_a, add_b  out  WIDTH  to adder dA/dB, registered
- add_done  in  1  from adder done
- add_result  in  WIDTH  from adder result
- add_carry  in  1  from adder carryOut

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is high, pick the first set bit searching from rr_ptr upward with wrap. Register grant index, add_a/add_b <= that requester's operands, clear counters -> ISSUE.
- ISSUE: add_start=1 for exactly START_CYC cycles -> WAIT.
- WAIT: add_start=0. add_done is sampled only in WAIT. On the first cycle add_done=1, capture add_result/add_carry, set rsp_err=0 -> RESP. Otherwise increment wdog. When wdog reaches TIMEOUT, result=0, carry=0, rsp_err=1 -> RESP.
- RESP: ack[grant]=1 for one cycle with the response fields. rr_ptr <= (grant+1) mod NREQ -> IDLE.
- A requester whose req is still high in the cycle after its ack is treated as a new request.
- req changes from non-granted requesters during an operation are ignored until IDLE.
- Arithmetic is done entirely by the adder. The block performs no width change; result is WIDTH bits and carry is separate.
- Reset (any state, asynchronous): state=IDLE, rr_ptr=0, add_start=0, add_a=add_b=0, ack=0, rsp_result=0, rsp_carry=0, rsp_err=0, busy=0, counters=0. An aborted operation is not acknowledged.

## Timing
- Request sampled in IDLE at edge n. ISSUE starts at n+1, add_start high during n+1..n+START_CYC. WAIT starts at n+START_CYC+1.
- add_done seen high at edge m in WAIT: ack high for cycle m+1, IDLE at m+2.
- Minimum req-to-ack latency is START_CYC + 2 + adder latency cycles.
- Back-to-back operations: the next grant can occur at the first IDLE cycle, so there is one idle cycle between operations.
- add_done high during ISSUE is ignored.
- Timeout: ack occurs TIMEOUT+1 cycles after WAIT entry.

## Structure
- Package adder_ctrl_pkg: state enum (IDLE, ISSUE, WAIT, RESP), START_CYC and TIMEOUT defaults, index-width function clog2.
- Sub-module rr_arbiter: combinational input (req, rr_ptr), outputs grant index and any_req. This block instantiates it once.

## Test plan
- Single request on req[0], op_a=0x17, op_b=0xF: add_start high for 2 cycles, then ack[0] pulse with rsp_result=0x26, carry=0, err=0.
- req[2], op_a=0x0000435567000009, op_b=0x0012345790000005: ack[2] with rsp_result=0x001277ACF700000E, carry=0.
- req[1], op_a=0xFFFFFFFFFFFFFFFF, op_b=0x1: rsp_result=0, rsp_carry=1.
- All four req high and held, reset pointer: ack order 0,1,2,3,0, each with that requester's sum; exactly one ack bit per RESP.
- Adder model never asserts done: after TIMEOUT+1 WAIT cycles, ack with rsp_err=1 and result=0; the next request is served normally.
- rst driven low mid-WAIT: all outputs zero immediately (asynchronous), no ack issued, first grant after release goes to requester 0.
